ins_fetch_queue: RTL
====================

Name: ins_fetch_queue

Overview:
Instruction fetch stage directly upstream of the memory controller.
- Holds the fetch PC and issues one 4-byte instruction read at a time over the memctrl instruction request/ok handshake.
- Buffers returned instruction words with their PCs in a circular FIFO.
- Presents the FIFO head to the issue/decode stage with a valid/pop handshake.
- On a pipeline clear, flushes everything and restarts fetch at a supplied PC.

Parameters:
- DEPTH, 16: number of FIFO entries; power of two, at least 2.
- PTR_W, 4: log2(DEPTH); pointer width.
- RESET_PC, 32'h0: fetch PC after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- rdy  in  1  global enable; low freezes all state.
- Clear_flag  in  1  pipeline flush request.
- clear_pc  in  32  restart PC, sampled when Clear_flag is high.
- insqueue_to_memctrl_needchange  out  1  fetch request strobe (combinational).
- memctrl_ins_addr_  out  32  fetch byte address; equals pc.
- memctrl_ins_remain_cycle_  out  4  constant 4, for a 4-byte read.
- memctrl_ins_ok__  in  1  one-cycle pulse: the fetched word is valid.
- memctrl_ins_ans__  in  32  fetched word, little-endian assembled.
- out_valid  out  1  FIFO non-empty.
- out_ins  out  32  head instruction.
- out_pc  out  32  head PC.
- issue_pop  in  1  consumer takes the head this cycle.
- fifo_count  out  PTR_W+1  occupancy, 0..DEPTH.

Interface: one clock, clk; reset rst is asynchronous and active-high. The polarity and synchronicity are fixed.

Behaviour:
- Reset (async assert, any time):
  - pc=RESET_PC, state=IDLE.
  - head=tail=0, count=0.
  - out_valid=0, out_ins=0, out_pc=0.
  - needchange=0.
  - Any in-flight fetch is abandoned.
- Priority at each posedge: rst > ~rdy (hold all state) > Clear_flag > normal operation.
- States:
  - IDLE: no fetch outstanding.
  - WAIT: one fetch outstanding; fetch_pc latched.
- needchange = rdy & ~rst & ~Clear_flag & (state==IDLE) & (count<DEPTH).
  - While needchange is high, addr_=pc and remain_cycle_=4.
  - When needchange is low, addr_ still shows pc; memctrl ignores it.
- IDLE -> WAIT on the edge where needchange=1; fetch_pc<=pc.
- WAIT, on memctrl_ins_ok__=1:
  - write {fetch_pc, ans} at tail; tail<=tail+1 modulo DEPTH.
  - pc<=fetch_pc+4, wrapping modulo 2^32.
  - state<=IDLE.
  - The next request is raised no earlier than the following cycle.
- memctrl_ins_ok__ while in IDLE: ignored (stale pulse).
- Pop: effective when issue_pop & out_valid; head<=head+1 modulo DEPTH.
  - issue_pop with empty FIFO: no effect.
- Count update per cycle: count += push - pop.
  - Simultaneous push and pop leaves count unchanged; legal at any occupancy, including DEPTH-1 and 1.
- Overflow is impossible: a request is made only when count<DEPTH, and at most one fetch is in flight.
- out_ins and out_pc are combinational reads of entry[head]; out_valid = (count!=0).
- Clear_flag=1 (with rdy=1):
  - head=tail=0, count=0, pc<=clear_pc, state<=IDLE.
  - A memctrl_ins_ok__ arriving in the same cycle is dropped.
  - A pop in the same cycle is ignored.
  - needchange=0 during the clear cycle; the first request at clear_pc goes out the next cycle.
  - Memctrl clears its own fetch state in the same cycle.
- rdy=0: no state change. needchange is forced 0, so memctrl never sees a request during the freeze.
- Fetch latency: request cycle to ok pulse is set by memctrl (~6 cycles when uncontended).
- Throughput: one instruction per (memctrl latency + 1) cycles.

Test Plan:
- Reset with RESET_PC=0, memory holds 0x00000013 at address 0 -> needchange=1 with addr 0 in the first cycle after reset. After the ok pulse: out_valid=1, out_ins=0x00000013, out_pc=0. The next request uses addr 4.
- No pops, fetches run continuously -> after 16 oks fifo_count=16 and needchange stays 0. One pop -> fifo_count=15 and needchange=1 the same cycle, with addr 0x40.
- FIFO at count 1 while in WAIT; ok and issue_pop coincide -> count stays 1, head advances, out_pc steps by 4.
- Clear_flag with clear_pc=0x100 during WAIT, with ok pulsing in that cycle -> count=0, out_valid=0, the word is dropped, and the next-cycle request uses addr 0x100.
- rdy held low for 5 cycles during WAIT and across an issue_pop -> count, pointers and pc unchanged, needchange=0. After rdy rises, normal operation resumes.
- Async rst asserted mid-cycle with count=7 -> outputs are zero immediately, before the next clock edge, and the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ins_fetch_queue.sv
// Instruction fetch queue: issues one 4-byte read at a time to memctrl and
// buffers the returned words with their PCs in a circular FIFO.
module ins_fetch_queue #(
  parameter int          DEPTH    = 16,
  parameter int          PTR_W    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             Clear_flag,
  input  logic [31:0]      clear_pc,
  output logic             insqueue_to_memctrl_needchange,
  output logic [31:0]      memctrl_ins_addr_,
  output logic [3:0]       memctrl_ins_remain_cycle_,
  input  logic             memctrl_ins_ok__,
  input  logic [31:0]      memctrl_ins_ans__,
  output logic             out_valid,
  output logic [31:0]      out_ins,
  output logic [31:0]      out_pc,
  input  logic             issue_pop,
  output logic [PTR_W:0]   fifo_count
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [31:0] ins_mem [DEPTH];
  logic [31:0] pc_mem  [DEPTH];

  logic push, pop, need;

  // Clear and freeze both suppress push/pop, so the FIFO never moves then.
  assign push = rdy & ~Clear_flag & (state_q == WAIT) & memctrl_ins_ok__;
  assign pop  = rdy & ~Clear_flag & issue_pop & (count_q != '0);
  assign need = rdy & ~rst & ~Clear_flag & (state_q == IDLE) &
                (count_q < (PTR_W+1)'(DEPTH));

  assign insqueue_to_memctrl_needchange = need;
  assign memctrl_ins_addr_              = pc_q;
  assign memctrl_ins_remain_cycle_      = 4'd4;

  assign out_valid  = (count_q != '0);
  assign out_ins    = out_valid ? ins_mem[head_q] : 32'h0;
  assign out_pc     = out_valid ? pc_mem[head_q]  : 32'h0;
  assign fifo_count = count_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (rdy) begin
      if (Clear_flag) begin
        state_d = IDLE;
        pc_d    = clear_pc;
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (need) begin
          state_d    = WAIT;
          fetch_pc_d = pc_q;
        end
        if (push) begin
          state_d = IDLE;
          pc_d    = fetch_pc_q + 32'd4;
          tail_d  = tail_q + PTR_W'(1);
        end
        if (pop) head_d = head_q + PTR_W'(1);
        count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: reads are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      ins_mem[tail_q] <= memctrl_ins_ans__;
      pc_mem[tail_q]  <= fetch_pc_q;
    end
  end

endmodule
